bus_arbiter_reg: RTL and testbench

Parametrised successor to the CPU's combinational datapath bus multiplexer. It selects one of NSRC source words onto the shared bus using a fixed priority, where the highest asserted index wins. It provides a same-cycle combinational bus and a registered bus copy. It holds the last driven value when no source is enabled, so the bus never floats or infers a latch. It detects multi-driver conflicts and counts them for debug.

---
 rtl/bus_arbiter_reg.sv | 150 +++++++++++++++
 tb/tb_bus_arbiter_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_reg.sv
// bus_arbiter_reg: fixed-priority shared-bus selector (highest enabled index wins).
// Provides a same-cycle combinational bus, a registered bus copy with a hold
// register, and multi-driver conflict detection with a sticky flag and a
// saturating counter.
// Optional build macro: BUS_ARBITER_PARITY_EN adds bus_par / par_chk_err.
module bus_arbiter_reg #(
    parameter  int WIDTH = 32,
    parameter  int NSRC  = 25,
    parameter  int CNT_W = 8,
    localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [WIDTH*NSRC-1:0]  src_data,
    input  logic [NSRC-1:0]        src_oe,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       bus_comb,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   bus_valid,
    output logic [SEL_W-1:0]       bus_sel,
    output logic                   conflict,
    output logic                   conflict_sticky,
    output logic [CNT_W-1:0]       conflict_cnt
`ifdef BUS_ARBITER_PARITY_EN
   ,output logic                   bus_par,
    output logic                   par_chk_err
`endif
);

    // Source words unpacked for readable indexing.
    logic [WIDTH-1:0] words [NSRC];

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_words
            assign words[gi] = src_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The hold register doubles as bus_out: both carry the last driven value.
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             conflict_q, conflict_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0] win_idx;
    logic [WIDTH-1:0] win_data;
    logic             any_en;
    logic             multi_en;

    // Priority select: later (higher) indices overwrite earlier ones; defaults
    // keep the encoder defined when no source is enabled.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_oe[i]) begin
                win_idx  = SEL_W'(i);
                win_data = words[i];
            end
        end
    end

    // Two or more enables: clearing the lowest set bit leaves something behind.
    assign any_en   = |src_oe;
    assign multi_en = |(src_oe & (src_oe - NSRC'(1)));

    assign bus_comb = any_en ? win_data : hold_q;

    // Next-state for bus copy, flags and the saturating conflict counter.
    always_comb begin
        hold_d     = hold_q;
        sel_d      = sel_q;
        valid_d    = any_en;
        conflict_d = multi_en;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;

        if (any_en) begin
            hold_d = win_data;
            sel_d  = win_idx;
        end

        // A fresh conflict outranks a clear request.
        if (multi_en) begin
            sticky_d = 1'b1;
        end else if (err_clr) begin
            sticky_d = 1'b0;
        end

        if (err_clr) begin
            cnt_d = multi_en ? CNT_W'(1) : '0;
        end else if (multi_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (clr) begin
            hold_q     <= '0;
            valid_q    <= 1'b0;
            sel_q      <= '0;
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            hold_q     <= hold_d;
            valid_q    <= valid_d;
            sel_q      <= sel_d;
            conflict_q <= conflict_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus_out         = hold_q;
    assign bus_valid       = valid_q;
    assign bus_sel         = sel_q;
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;
    assign conflict_cnt    = cnt_q;

`ifdef BUS_ARBITER_PARITY_EN
    logic par_q, par_d;
    logic par_err_q, par_err_d;

    // Parity travels with the loaded word; checker compares stored pair.
    always_comb begin
        par_d     = any_en ? (^win_data) : par_q;
        par_err_d = (^hold_q) != par_q;
    end

    // Parity and checker registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_q     <= par_d;
            par_err_q <= par_err_d;
        end
    end

    assign bus_par     = par_q;
    assign par_chk_err = par_err_q;
`endif

endmodule

// File: tb/tb_bus_arbiter_reg.sv
// Testbench for bus_arbiter_reg: directed scenarios followed by randomized
// traffic, all checked against a behavioural reference model.
module tb_bus_arbiter_reg;

    localparam int WIDTH = 32;
    localparam int NSRC  = 25;
    localparam int CNT_W = 2;
    localparam int SEL_W = $clog2(NSRC);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  clr;
    logic [WIDTH*NSRC-1:0] src_data;
    logic [NSRC-1:0]       src_oe;
    logic                  err_clr;
    logic [WIDTH-1:0]      bus_comb;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [SEL_W-1:0]      bus_sel;
    logic                  conflict;
    logic                  conflict_sticky;
    logic [CNT_W-1:0]      conflict_cnt;
`ifdef BUS_ARBITER_PARITY_EN
    logic                  bus_par;
    logic                  par_chk_err;
`endif

    bus_arbiter_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .clr             (clr),
        .src_data        (src_data),
        .src_oe          (src_oe),
        .err_clr         (err_clr),
        .bus_comb        (bus_comb),
        .bus_out         (bus_out),
        .bus_valid       (bus_valid),
        .bus_sel         (bus_sel),
        .conflict        (conflict),
        .conflict_sticky (conflict_sticky),
        .conflict_cnt    (conflict_cnt)
`ifdef BUS_ARBITER_PARITY_EN
       ,.bus_par         (bus_par),
        .par_chk_err     (par_chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    // Reference model state (what the bus should be showing).
    logic [WIDTH-1:0] m_out;
    logic             m_valid;
    int               m_sel;
    logic             m_conf;
    logic             m_sticky;
    int               m_cnt;
    logic             m_par;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] word_of(input logic [WIDTH*NSRC-1:0] d, input int i);
        return d[i*WIDTH +: WIDTH];
    endfunction

    // Highest set index, or -1 when nothing is enabled.
    function automatic int top_index(input logic [NSRC-1:0] oe);
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (oe[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_update(input logic c, input logic [NSRC-1:0] oe,
                                input logic [WIDTH*NSRC-1:0] d, input logic e);
        int  w;
        bit  cf;
        if (c) begin
            m_out = '0; m_valid = 0; m_sel = 0; m_conf = 0;
            m_sticky = 0; m_cnt = 0; m_par = 0;
        end else begin
            w  = top_index(oe);
            cf = ($countones(oe) >= 2);
            if (w >= 0) begin
                m_out   = word_of(d, w);
                m_sel   = w;
                m_valid = 1;
                m_par   = ^word_of(d, w);
            end else begin
                m_valid = 0;
            end
            m_conf = cf;
            if (cf)       m_sticky = 1;
            else if (e)   m_sticky = 0;
            if (e)        m_cnt = cf ? 1 : 0;
            else if (cf)  m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
    endtask

    // One transaction: drive, check comb bus, clock, check registered outputs.
    task automatic step(input logic c, input logic [NSRC-1:0] oe,
                        input logic [WIDTH*NSRC-1:0] d, input logic e);
        int               w;
        logic [WIDTH-1:0] exp_comb;
        clr = c; src_oe = oe; src_data = d; err_clr = e;
        #1;
        w = top_index(oe);
        exp_comb = (w >= 0) ? word_of(d, w) : m_out;
        check_eq("bus_comb", 64'(bus_comb), 64'(exp_comb));
        @(posedge clk);
        model_update(c, oe, d, e);
        #1;
        n_txn++;
        $display("[TB] txn %0d clr=%0d oe=%07h err_clr=%0d -> out=%08h sel=%0d v=%0d cf=%0d st=%0d cnt=%0d",
                 n_txn, c, oe, e, bus_out, bus_sel, bus_valid, conflict, conflict_sticky, conflict_cnt);
        check_eq("bus_out",   64'(bus_out),         64'(m_out));
        check_eq("bus_valid", 64'(bus_valid),       64'(m_valid));
        check_eq("bus_sel",   64'(bus_sel),         64'(m_sel));
        check_eq("conflict",  64'(conflict),        64'(m_conf));
        check_eq("sticky",    64'(conflict_sticky), 64'(m_sticky));
        check_eq("cnt",       64'(conflict_cnt),    64'(m_cnt));
`ifdef BUS_ARBITER_PARITY_EN
        check_eq("bus_par",     64'(bus_par),     64'(m_par));
        check_eq("par_chk_err", 64'(par_chk_err), 64'(0));
`endif
    endtask

    function automatic logic [WIDTH*NSRC-1:0] rand_data();
        logic [WIDTH*NSRC-1:0] d;
        for (int i = 0; i < NSRC; i++) d[i*WIDTH +: WIDTH] = $urandom;
        return d;
    endfunction

    function automatic logic [NSRC-1:0] rand_oe();
        logic [NSRC-1:0] oe;
        int k;
        oe = '0;
        k = $urandom_range(0, 3);
        case (k)
            0: oe = '0;
            1: oe[$urandom_range(0, NSRC - 1)] = 1'b1;
            2: begin
                oe[$urandom_range(0, NSRC - 1)] = 1'b1;
                oe[$urandom_range(0, NSRC - 1)] = 1'b1;
            end
            default: oe = NSRC'($urandom);
        endcase
        return oe;
    endfunction

    logic [WIDTH*NSRC-1:0] d;
    logic [NSRC-1:0]       oe;

    initial begin
        clr = 1'b1; src_oe = '0; src_data = '0; err_clr = 1'b0;
        m_out = '0; m_valid = 0; m_sel = 0; m_conf = 0; m_sticky = 0; m_cnt = 0; m_par = 0;
        @(posedge clk); #1;

        // Reset with random traffic on the inputs.
        step(1'b1, rand_oe(), rand_data(), 1'b1);
        step(1'b1, rand_oe(), rand_data(), 1'b0);
        check_eq("rst_bus_out", 64'(bus_out), 64'(0));
        step(1'b0, '0, rand_data(), 1'b0);
        check_eq("rst_release_comb", 64'(bus_comb), 64'(0));

        // Single driver on source 3.
        d = rand_data();
        d[3*WIDTH +: WIDTH] = 32'h0000_1234;
        oe = '0; oe[3] = 1'b1;
        step(1'b0, oe, d, 1'b0);
        check_eq("single_out", 64'(bus_out), 64'h1234);
        check_eq("single_sel", 64'(bus_sel), 64'd3);

        // Hold for three idle cycles.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, rand_data(), 1'b0);
            check_eq("hold_comb", 64'(bus_comb), 64'h1234);
            check_eq("hold_valid", 64'(bus_valid), 64'd0);
        end

        // Conflict between sources 2 and 20: higher index wins.
        d = rand_data();
        d[2*WIDTH +: WIDTH]  = 32'h0000_AAAA;
        d[20*WIDTH +: WIDTH] = 32'h0000_5555;
        oe = '0; oe[2] = 1'b1; oe[20] = 1'b1;
        step(1'b0, oe, d, 1'b0);
        check_eq("prio_out", 64'(bus_out), 64'h5555);
        check_eq("prio_sel", 64'(bus_sel), 64'd20);
        check_eq("prio_cnt", 64'(conflict_cnt), 64'd1);

        // Five more conflicts: counter saturates.
        for (int i = 0; i < 5; i++) step(1'b0, oe, rand_data(), 1'b0);
        check_eq("sat_cnt", 64'(conflict_cnt), 64'(CMAX));

        // Clear without conflict, then clear together with a conflict.
        step(1'b0, '0, rand_data(), 1'b1);
        check_eq("clr_cnt", 64'(conflict_cnt), 64'd0);
        check_eq("clr_sticky", 64'(conflict_sticky), 64'd0);
        step(1'b0, oe, rand_data(), 1'b1);
        check_eq("clr_conf_cnt", 64'(conflict_cnt), 64'd1);
        check_eq("clr_conf_sticky", 64'(conflict_sticky), 64'd1);

        // Parity vectors (meaningful when the parity build is enabled).
        d = rand_data();
        d[5*WIDTH +: WIDTH] = 32'h0000_0007;
        oe = '0; oe[5] = 1'b1;
        step(1'b0, oe, d, 1'b0);
`ifdef BUS_ARBITER_PARITY_EN
        check_eq("par_7", 64'(bus_par), 64'd1);
`endif
        d[5*WIDTH +: WIDTH] = 32'h0000_0003;
        step(1'b0, oe, d, 1'b0);
`ifdef BUS_ARBITER_PARITY_EN
        check_eq("par_3", 64'(bus_par), 64'd0);
`endif

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), rand_oe(), rand_data(),
                 ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
